// File: rtl/serial_adder_ctrl_if.sv
// Handshake bundle for the bit-serial adder: operand channel (in_*) and
// result channel (out_*), plus the busy status flag.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    // Producer/consumer side: drives operands and result acceptance.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-add cell (two half adders + OR) reused over
// WIDTH clocks, with valid/ready handshakes on operands and result.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    // One-bit full-add cell built from two half adders.
    logic p_bit, g0_bit, s_bit, g1_bit, c_bit;

    half_adder u_ha0 (
        .x (a_sh_q[0]),
        .y (b_sh_q[0]),
        .s (p_bit),
        .c (g0_bit)
    );

    half_adder u_ha1 (
        .x (p_bit),
        .y (carry_q),
        .s (s_bit),
        .c (g1_bit)
    );

    assign c_bit = g0_bit | g1_bit;

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    // A one-bit result has nothing to shift, so it is just the new bit.
    logic [WIDTH-1:0] sum_shift;
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_shift = s_bit;
        end else begin : g_wn
            assign sum_shift = {s_bit, sum_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state and datapath update for the IDLE/ADD/DONE sequence.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = sum_shift;
                carry_d = c_bit;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    cout_d  = c_bit;
                    state_d = DONE;
                end
            end
            DONE: begin
                // No bypass to a new accept: in_ready only rises once back in IDLE.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == ADD) || (state_d == DONE);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 functional/handshake cases
// and an exhaustive WIDTH=2 back-to-back sweep.
module tb_serial_adder_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(2)) bus2 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete WIDTH=8 transaction with out_ready held high.
    task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
        int lat;
        int busy_cnt;
        bus8.out_ready = 1'b1;
        bus8.a         = a;
        bus8.b         = b;
        bus8.cin       = cin;
        bus8.in_valid  = 1'b1;
        tick();                                  // accept edge
        bus8.in_valid  = 1'b0;
        bus8.a         = 8'hEE;                  // must be ignored after accept
        bus8.b         = 8'hEE;
        bus8.cin       = 1'b1;
        check({tag, "_accepted"}, {31'd0, bus8.in_ready}, 32'd0);
        busy_cnt = bus8.busy ? 1 : 0;
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            tick();
            lat++;
            if (bus8.busy) busy_cnt++;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_sum"}, {24'd0, bus8.sum}, {24'd0, exp_sum});
        check({tag, "_cout"}, {31'd0, bus8.cout}, {31'd0, exp_cout});
        tick();                                  // DONE -> IDLE
        check({tag, "_busy_cycles"}, busy_cnt, 9);
        check({tag, "_idle"}, {29'd0, bus8.in_ready, bus8.out_valid, bus8.busy}, 32'b100);
        check({tag, "_sum_hold"}, {23'd0, bus8.cout, bus8.sum}, {23'd0, exp_cout, exp_sum});
        $display("op %s: a=0x%02h b=0x%02h cin=%0d -> sum=0x%02h cout=%0d lat=%0d",
                 tag, a, b, cin, bus8.sum, bus8.cout, lat);
    endtask

    initial begin
        int lat;
        int prev_acc;
        int acc;
        logic seen_valid;
        logic [7:0] hold_sum;

        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.out_ready = 1'b0;

        // Reset held for 3 cycles, then released.
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        check("reset_in_ready", {31'd0, bus8.in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, bus8.out_valid}, 32'd0);
        check("reset_busy", {31'd0, bus8.busy}, 32'd0);
        check("reset_sum_cout", {23'd0, bus8.cout, bus8.sum}, 32'd0);
        $display("reset: in_ready=%0d out_valid=%0d busy=%0d sum=0x%02h cout=%0d",
                 bus8.in_ready, bus8.out_valid, bus8.busy, bus8.sum, bus8.cout);

        // Basic add and carry chain.
        run_op8("basic",   8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        run_op8("carry_ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op8("carry_ffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op8("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // Backpressure with a second operand set waiting behind it.
        bus8.out_ready = 1'b0;
        bus8.a = 8'h0F; bus8.b = 8'h01; bus8.cin = 1'b0;
        bus8.in_valid = 1'b1;
        tick();
        bus8.a = 8'h10; bus8.b = 8'h20;           // in_valid stays high throughout
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp_latency", lat, 8);
        check("bp_first_sum", {23'd0, bus8.cout, bus8.sum}, 32'h010);
        hold_sum = bus8.sum;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {20'd0, bus8.out_valid, bus8.in_ready, bus8.cout, 1'b0, bus8.sum},
                  {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, hold_sum});
            $display("bp stall %0d: out_valid=%0d sum=0x%02h", i, bus8.out_valid, bus8.sum);
        end
        bus8.out_ready = 1'b1;
        tick();                                   // result handshake, no same-edge accept
        check("bp_handshake_idle", {30'd0, bus8.in_ready, bus8.busy}, 32'b10);
        tick();                                   // second operand set accepted here
        bus8.in_valid = 1'b0;
        check("bp_second_accept", {30'd0, bus8.in_ready, bus8.busy}, 32'b01);
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp_second_latency", lat, 8);
        check("bp_second_sum", {23'd0, bus8.cout, bus8.sum}, 32'h030);
        $display("bp second op: sum=0x%02h cout=%0d", bus8.sum, bus8.cout);
        tick();

        // Reset during the 4th ADD cycle.
        bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {20'd0, bus8.in_ready, bus8.out_valid, bus8.busy, bus8.cout, bus8.sum},
              {20'd0, 4'b1000, 8'h00});
        tick();
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_valid", {31'd0, seen_valid}, 32'd0);
        $display("mid-op reset: out_valid seen=%0d", seen_valid);
        run_op8("after_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        // Exhaustive WIDTH=2 sweep, back-to-back.
        bus2.out_ready = 1'b1;
        bus2.in_valid  = 1'b1;
        prev_acc = 0;
        for (int idx = 0; idx < 32; idx++) begin
            lat = 0;
            while (!bus2.in_ready && lat < 20) begin
                tick();
                lat++;
            end
            bus2.a   = 2'(idx >> 3);
            bus2.b   = 2'(idx >> 1);
            bus2.cin = idx[0];
            tick();
            acc = cyc;
            check("w2_accept", {31'd0, bus2.busy}, 32'd1);
            if (idx > 0) check("w2_period", acc - prev_acc, 4);
            prev_acc = acc;
            lat = 0;
            while (!bus2.out_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("w2_latency", lat, 2);
            check("w2_result", {29'd0, bus2.cout, bus2.sum},
                  32'((idx >> 3) & 3) + 32'((idx >> 1) & 3) + 32'(idx & 1));
            $display("w2 op %0d: a=%0d b=%0d cin=%0d -> cout=%0d sum=%0d",
                     idx, (idx >> 3) & 3, (idx >> 1) & 3, idx & 1, bus2.cout, bus2.sum);
            tick();
        end
        bus2.in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial multi-bit adder controller that sequences a single one-bit add cell over WIDTH cycles. The cell is two `half_adder` instances plus an OR for carry. Operands and results move over valid/ready handshakes, so the block can sit between any producer and consumer in the arithmetic test datapath. It trades latency for area: one bit per clock, with one carry flop holding state between bits.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH ≥ 1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set presented
- in_ready  out  1  block can accept operands; equals (state == IDLE)
- a  in  WIDTH  operand A, sampled only on the accept edge
- b  in  WIDTH  operand B, sampled only on the accept edge
- cin  in  1  carry-in, sampled only on the accept edge
- out_valid  out  1  result available; equals (state == DONE)
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH, registered
- cout  out  1  carry out of bit WIDTH-1, registered
- busy  out  1  high in ADD and DONE

## Operation
- FSM states: IDLE, ADD, DONE. Reset puts the FSM in IDLE.
- IDLE
  - Accept occurs when in_valid && in_ready.
  - On accept: load a_sh←a, b_sh←b, carry←cin, cnt←0, sum←0; go to ADD.
- ADD, each cycle:
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0])).
  - Update: sum ← {s, sum[WIDTH-1:1]}; a_sh/b_sh shift right one bit (zero fill); carry←c; cnt←cnt+1.
  - When cnt == WIDTH-1 this cycle, go to DONE and latch cout←c. After that edge, sum holds the full result LSB-aligned.
- DONE
  - sum and cout are held stable.
  - On out_ready, go to IDLE. sum and cout keep their values until the next accept.
- cnt width is $clog2(WIDTH+1).
- Arithmetic is unsigned. Overflow is reported only through cout.
- The a, b and cin inputs are ignored outside the accept edge.
- There is no DONE→accept bypass: in_ready is low in DONE even when out_ready is high.

## Timing
- Reset values (asynchronous, immediate on rst_n low): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry=0, cnt=0.
- Latency: if accept happens at edge E0, out_valid rises at edge E(WIDTH), after exactly WIDTH ADD cycles.
- Throughput: with out_ready held high and in_valid held high, accepts occur every WIDTH+2 cycles. The sequence is accept, WIDTH ADD edges, DONE→IDLE edge, then the next accept.
- Busy window: in_valid while busy is not accepted. The producer must hold the operands until in_ready is high.
- Backpressure: out_ready low keeps the block in DONE indefinitely. out_valid, sum and cout stay constant.
- Simultaneous out_ready and in_valid in DONE: the result handshake completes. The new operands are accepted on the following edge, not the same one.
- WIDTH=1: ADD lasts one cycle; cnt==0 is terminal.
- Reset mid-operation (ADD or DONE): the in-flight operation is discarded with no out_valid pulse. After rst_n deasserts, the first accept behaves normally.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → in_ready=1, out_valid=0, busy=0, sum=0x00, cout=0.
- Basic add, WIDTH=8: a=0x5A, b=0x33, cin=0 → out_valid rises exactly 8 edges after accept; sum=0x8D, cout=0. Check busy is high for 9 cycles with out_ready=1.
- Carry chain:
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
  - a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Backpressure and busy input:
  - Hold out_ready=0 for 5 cycles after out_valid → sum and cout stay stable and out_valid stays high.
  - Drive a second operand set (a=0x10, b=0x20) with in_valid=1 throughout → it is accepted only after the result handshake, one cycle later. Its result is sum=0x30.
- Reset mid-op: pulse rst_n low during the 4th ADD cycle of a=0xAA, b=0x55 → no out_valid pulse, outputs return to reset values. A following a=0x01, b=0x02 gives sum=0x03.
- Exhaustive, WIDTH=2:
  - All 32 combinations of a, b and cin, back-to-back, with out_ready=1 and in_valid=1 → each {cout, sum} equals a+b+cin.
  - Accept-to-accept period is exactly 4 cycles.
